// File: rtl/alu_resp_deser.sv
// alu_resp_deser: serial response receiver for the ALU sout line.
// Rebuilds 11-bit frames into either a data response (4 DATA + 1 CMD frame)
// or a single error frame, checks CRC3/parity/framing, and strobes one result
// per response. An armed command with no reply yields NO_TRANSMISSION.
module alu_resp_deser #(
  parameter int unsigned TIMEOUT = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  input  logic        arm,
  output logic        result_valid,
  output logic [1:0]  result,
  output logic [31:0] c_out,
  output logic [3:0]  alu_flags,
  output logic [2:0]  crc3b,
  output logic        crc_ok,
  output logic [5:0]  err_flags,
  output logic        parity,
  output logic        parity_ok,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RX,
    HUNT,
    DONE
  } state_t;

  typedef struct packed {
    logic [1:0]  result;
    logic [31:0] c;
    logic [3:0]  flags;
    logic [2:0]  crc;
    logic        crc_ok;
    logic [5:0]  err;
    logic        par;
    logic        par_ok;
    logic        ferr;
  } resp_t;

  localparam resp_t       NO_TX_RESP = '{result: 2'b10, default: '0};
  // The timer is loaded with TIMEOUT-1 so that expiry on tmr==1 puts the
  // strobe exactly TIMEOUT cycles after the arm edge.
  localparam logic [15:0] TMR_LOAD   = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] tmr;
  logic [3:0]  bitcnt;
  logic [8:0]  shreg;
  logic [2:0]  k;
  logic [31:0] c_acc;
  resp_t       pend;
  resp_t       resp_q;

  logic        frame_type;
  logic [7:0]  payload;
  logic [2:0]  crc_calc;
  logic        par_calc;
  logic        rx_more;
  resp_t       rx_resp;

  // CRC3, polynomial x^3+x+1, init 000, processed MSB first.
  function automatic logic [2:0] crc3_calc(input logic [36:0] msg);
    logic [2:0] crc;
    logic       fb;
    crc = '0;
    for (int unsigned i = 0; i < 37; i++) begin
      fb  = crc[2] ^ msg[6'(36 - i)];
      crc = {crc[1:0], 1'b0} ^ {1'b0, fb, fb};
    end
    return crc;
  endfunction

  assign frame_type = shreg[8];
  assign payload    = shreg[7:0];
  assign crc_calc   = crc3_calc({c_acc, 1'b0, payload[6:3]});
  assign par_calc   = ^{1'b1, payload[6:1]};

  // Classify a completed frame (valid when the stop bit is on sin).
  always_comb begin
    rx_resp = '0;
    rx_more = 1'b0;
    if (!sin) begin
      rx_resp.result = 2'b01;
      rx_resp.ferr   = 1'b1;
    end else if (!frame_type) begin
      if (k < 3'd4) begin
        rx_more = 1'b1;
      end else begin
        rx_resp.result = 2'b01;
        rx_resp.ferr   = 1'b1;
      end
    end else if ((k == 3'd4) && !payload[7]) begin
      rx_resp.result = 2'b00;
      rx_resp.c      = c_acc;
      rx_resp.flags  = payload[6:3];
      rx_resp.crc    = payload[2:0];
      rx_resp.crc_ok = (payload[2:0] == crc_calc);
    end else if ((k == 3'd0) && payload[7]) begin
      rx_resp.result = 2'b01;
      rx_resp.err    = payload[6:1];
      rx_resp.par    = payload[0];
      rx_resp.par_ok = (payload[0] == par_calc);
    end else begin
      rx_resp.result = 2'b01;
      rx_resp.ferr   = 1'b1;
    end
  end

  // Receive FSM, timeout counter and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tmr          <= '0;
      bitcnt       <= '0;
      shreg        <= '0;
      k            <= '0;
      c_acc        <= '0;
      pend         <= '0;
      resp_q       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          k <= '0;
          if (!sin) begin
            state  <= RX;
            bitcnt <= 4'd1;
          end else if (arm) begin
            if (TIMEOUT == 1) begin
              pend  <= NO_TX_RESP;
              state <= DONE;
            end else begin
              tmr   <= TMR_LOAD;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!sin) begin
            state  <= RX;
            bitcnt <= 4'd1;
          end else if (arm) begin
            tmr <= TMR_LOAD;
          end else if (tmr == 16'd1) begin
            pend  <= NO_TX_RESP;
            state <= DONE;
          end else begin
            tmr <= tmr - 16'd1;
          end
        end
        RX: begin
          if (bitcnt == 4'd10) begin
            bitcnt <= '0;
            if (rx_more) begin
              c_acc <= {c_acc[23:0], payload};
              k     <= k + 3'd1;
              state <= HUNT;
            end else begin
              pend  <= rx_resp;
              state <= DONE;
            end
          end else begin
            shreg  <= {shreg[7:0], sin};
            bitcnt <= bitcnt + 4'd1;
          end
        end
        HUNT: begin
          if (!sin) begin
            state  <= RX;
            bitcnt <= 4'd1;
          end
        end
        DONE: begin
          result_valid <= 1'b1;
          resp_q       <= pend;
          k            <= '0;
          c_acc        <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign result    = resp_q.result;
  assign c_out     = resp_q.c;
  assign alu_flags = resp_q.flags;
  assign crc3b     = resp_q.crc;
  assign crc_ok    = resp_q.crc_ok;
  assign err_flags = resp_q.err;
  assign parity    = resp_q.par;
  assign parity_ok = resp_q.par_ok;
  assign frame_err = resp_q.ferr;
  assign busy      = (state == RX) || (state == HUNT);

endmodule

// File: tb/tb_alu_resp_deser.sv
// Scoreboard bench for alu_resp_deser: stimulus pushes expected responses,
// a negedge monitor pops and compares on every result_valid strobe.
module tb_alu_resp_deser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b1;
  logic        arm = 1'b0;
  logic        result_valid;
  logic [1:0]  result;
  logic [31:0] c_out;
  logic [3:0]  alu_flags;
  logic [2:0]  crc3b;
  logic        crc_ok;
  logic [5:0]  err_flags;
  logic        parity;
  logic        parity_ok;
  logic        frame_err;
  logic        busy;

  alu_resp_deser #(.TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .arm(arm),
    .result_valid(result_valid), .result(result), .c_out(c_out),
    .alu_flags(alu_flags), .crc3b(crc3b), .crc_ok(crc_ok),
    .err_flags(err_flags), .parity(parity), .parity_ok(parity_ok),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  result;
    logic [31:0] c;
    logic [3:0]  flags;
    logic [2:0]  crc;
    logic        crc_ok;
    logic [5:0]  err;
    logic        par;
    logic        par_ok;
    logic        ferr;
    int unsigned at;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [1:0] r, input logic [31:0] c, input logic [3:0] f,
                      input logic [2:0] crc, input logic cok, input logic [5:0] err,
                      input logic par, input logic pok, input logic ferr, input int unsigned at);
    exp_t x;
    x.result = r; x.c = c; x.flags = f; x.crc = crc; x.crc_ok = cok;
    x.err = err; x.par = par; x.par_ok = pok; x.ferr = ferr; x.at = at;
    sb.push_back(x);
  endtask

  // Monitor: compare every strobe against the oldest expected response.
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_strobe: got strobe at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("strobe_cycle", cyc, e.at);
        check("result", {30'd0, result}, {30'd0, e.result});
        check("c_out", c_out, e.c);
        check("alu_flags", {28'd0, alu_flags}, {28'd0, e.flags});
        check("crc3b", {29'd0, crc3b}, {29'd0, e.crc});
        check("crc_ok", {31'd0, crc_ok}, {31'd0, e.crc_ok});
        check("err_flags", {26'd0, err_flags}, {26'd0, e.err});
        check("parity", {31'd0, parity}, {31'd0, e.par});
        check("parity_ok", {31'd0, parity_ok}, {31'd0, e.par_ok});
        check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] pl, input logic stop,
                            output int unsigned last);
    logic [10:0] fr;
    fr = {1'b0, typ, pl, stop};
    for (int i = 10; i >= 0; i--) begin
      sin = fr[i];
      @(posedge clk);
      #1;
    end
    sin = 1'b1;
    last = cyc;
  endtask

  task automatic send_data(input logic [31:0] c, input logic [7:0] ctl, output int unsigned last);
    int unsigned t;
    for (int i = 3; i >= 0; i--) begin
      send_frame(1'b0, c[i*8 +: 8], 1'b1, t);
      idle(2);
    end
    send_frame(1'b1, ctl, 1'b1, last);
  endtask

  int unsigned last;
  int unsigned a_cyc;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_result_valid", {31'd0, result_valid}, 32'd0);
    check("rst_result", {30'd0, result}, 32'd0);
    check("rst_c_out", c_out, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Data response C=3, flags 0000, CRC 110 (good)
    send_data(32'h0000_0003, 8'h06, last);
    push(2'b00, 32'h3, 4'h0, 3'b110, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, last + 1);
    idle(3);
    // Same with CRC 111 (bad)
    send_data(32'h0000_0003, 8'h07, last);
    push(2'b00, 32'h3, 4'h0, 3'b111, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, last + 1);
    idle(3);
    // C=0x80000001, flags 1010, CRC 111 (good)
    send_data(32'h8000_0001, 8'h57, last);
    push(2'b00, 32'h8000_0001, 4'hA, 3'b111, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, last + 1);
    idle(3);
    // Error frames: good parity then bad parity
    send_frame(1'b1, 8'hC9, 1'b1, last);
    push(2'b01, 32'd0, 4'd0, 3'd0, 1'b0, 6'b100100, 1'b1, 1'b1, 1'b0, last + 1);
    idle(3);
    send_frame(1'b1, 8'hC8, 1'b1, last);
    push(2'b01, 32'd0, 4'd0, 3'd0, 1'b0, 6'b100100, 1'b0, 1'b0, 1'b0, last + 1);
    idle(3);

    // Timeout: arm, line idle -> NO_TRANSMISSION 100 cycles later
    arm = 1'b1;
    @(posedge clk);
    #1;
    a_cyc = cyc;
    arm = 1'b0;
    push(2'b10, 32'd0, 4'd0, 3'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, a_cyc + 100);
    idle(20);
    check("wait_not_busy", {31'd0, busy}, 32'd0);
    idle(90);

    // Start bit sampled on the 99th cycle after arm: no timeout strobe
    arm = 1'b1;
    @(posedge clk);
    #1;
    a_cyc = cyc;
    arm = 1'b0;
    idle(98);
    send_frame(1'b1, 8'hC9, 1'b1, last);
    check("late_start_last", last, a_cyc + 109);
    push(2'b01, 32'd0, 4'd0, 3'd0, 1'b0, 6'b100100, 1'b1, 1'b1, 1'b0, last + 1);
    idle(3);

    // Two DATA frames then CMD -> framing error
    send_frame(1'b0, 8'h11, 1'b1, last);
    idle(2);
    check("hunt_busy", {31'd0, busy}, 32'd1);
    send_frame(1'b0, 8'h22, 1'b1, last);
    idle(2);
    send_frame(1'b1, 8'h06, 1'b1, last);
    push(2'b01, 32'd0, 4'd0, 3'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, last + 1);
    idle(3);
    // Stop bit 0 -> framing error
    send_frame(1'b0, 8'h55, 1'b0, last);
    push(2'b01, 32'd0, 4'd0, 3'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, last + 1);
    idle(3);
    // Recovery: C=0xFF, flags 0001, CRC 001
    send_data(32'h0000_00FF, 8'h09, last);
    push(2'b00, 32'hFF, 4'h1, 3'b001, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, last + 1);
    idle(3);

    // Reset in the middle of the 3rd data frame
    send_frame(1'b0, 8'hAA, 1'b1, last);
    idle(2);
    send_frame(1'b0, 8'hBB, 1'b1, last);
    idle(2);
    sin = 1'b0; idle(1);
    sin = 1'b0; idle(1);
    sin = 1'b1; idle(1);
    sin = 1'b1; idle(1);
    sin = 1'b0; idle(1);
    check("mid_frame_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_c_out", c_out, 32'd0);
    check("arst_alu_flags", {28'd0, alu_flags}, 32'd0);
    check("arst_crc3b", {29'd0, crc3b}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_result_valid", {31'd0, result_valid}, 32'd0);
    sin = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    send_data(32'h8000_0001, 8'h57, last);
    push(2'b00, 32'h8000_0001, 4'hA, 3'b111, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, last + 1);
    idle(5);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
